load_store_unit: RTL and testbench

Initiator for the data port of the word-addressed data RAM. Takes one byte/halfword/word load or store request at a time from the execute stage, drives the RAM's word address, read strobe, write strobe and write data, and returns an aligned, sign- or zero-extended load result. Sub-word stores are done as read-modify-write, because the RAM only supports full-word writes.

---
 rtl/load_store_unit.sv | 194 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: data-port initiator for a word-addressed RAM.
// Handles byte/half/word loads and stores; sub-word stores use a
// read-modify-write because the RAM only takes full-word writes.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned accesses return
// resp_error instead of being forced to the aligned lane).
//
// Handshake: a request is taken on a clock edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, so at most one
// request is in flight. resp_valid is a one-cycle pulse with no backpressure.

`ifndef ARCH_WIDTH
`define ARCH_WIDTH 32
`endif

module load_store_unit #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [`ARCH_WIDTH-1:0] req_addr,
  input  logic [`ARCH_WIDTH-1:0] req_wdata,
  output logic                   resp_valid,
  output logic [`ARCH_WIDTH-1:0] resp_data,
  output logic                   resp_error,
  output logic [DEPTH_LOG2-1:0]  mem_addr,
  output logic                   mem_rd,
  input  logic [`ARCH_WIDTH-1:0] mem_rdata,
  output logic                   mem_wr,
  output logic [`ARCH_WIDTH-1:0] mem_wdata
);
  localparam int W = `ARCH_WIDTH;

  typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} state_e;

  state_e                state_q;
  logic                  write_q;
  logic                  byte_q;
  logic                  half_q;
  logic                  unsigned_q;
  logic [1:0]            off_q;
  logic [DEPTH_LOG2-1:0] widx_q;
  logic [15:0]           wdata_q;

  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic [W-1:0]          resp_data_q;
  logic                  resp_error_q;
  logic [DEPTH_LOG2-1:0] mem_addr_q;
  logic                  mem_rd_q;
  logic                  mem_wr_q;
  logic [W-1:0]          mem_wdata_q;

  logic                  in_byte;
  logic                  in_half;
  logic                  in_trap;
  logic [1:0]            in_off;
  logic [DEPTH_LOG2-1:0] in_widx;
  logic [4:0]            sh;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [W-1:0]          load_d;
  logic [W-1:0]          merged_d;

  // Address bits above the RAM index are deliberately ignored (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[W-1:DEPTH_LOG2+2];

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_error = resp_error_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wdata  = mem_wdata_q;

  // Decode the incoming request: size class, effective lane offset, trap.
  always_comb begin
    in_byte = (req_size == 2'd0);
    in_half = (req_size == 2'd1);
    in_widx = req_addr[DEPTH_LOG2+1:2];
    if (in_byte)      in_off = req_addr[1:0];
    else if (in_half) in_off = {req_addr[1], 1'b0};
    else              in_off = 2'b00;
`ifdef MISALIGN_TRAP_EN
    in_trap = (in_half && req_addr[0]) ||
              (!in_byte && !in_half && (req_addr[1:0] != 2'b00));
`else
    in_trap = 1'b0;
`endif
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    sh     = {off_q, 3'b000};
    byte_v = 8'(mem_rdata >> sh);
    half_v = 16'(mem_rdata >> sh);
    if (byte_q)      load_d = {{(W-8){byte_v[7] & ~unsigned_q}}, byte_v};
    else if (half_q) load_d = {{(W-16){half_v[15] & ~unsigned_q}}, half_v};
    else             load_d = mem_rdata;
    if (byte_q)
      merged_d = (mem_rdata & ~(W'(8'hFF) << sh)) | (W'(wdata_q[7:0]) << sh);
    else
      merged_d = (mem_rdata & ~(W'(16'hFFFF) << sh)) | (W'(wdata_q) << sh);
  end

  // Control FSM with registered memory-side and response outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      byte_q       <= 1'b0;
      half_q       <= 1'b0;
      unsigned_q   <= 1'b0;
      off_q        <= 2'b00;
      widx_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      // Outputs default to 0 and are raised only on entry to their state.
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wdata_q  <= '0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            write_q     <= req_write;
            byte_q      <= in_byte;
            half_q      <= in_half;
            unsigned_q  <= req_unsigned;
            off_q       <= in_off;
            widx_q      <= in_widx;
            wdata_q     <= req_wdata[15:0];
            if (in_trap) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
            end else if (req_write && !in_byte && !in_half) begin
              state_q     <= WR;
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= in_widx;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q    <= RD;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= in_widx;
            end
          end
        end
        RD: state_q <= DATA;
        DATA: begin
          if (write_q) begin
            state_q     <= WR;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= widx_q;
            mem_wdata_q <= merged_d;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= load_d;
          end
        end
        WR: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: RAM model, directed and random requests,
// a behavioural reference memory and one summary line.
`timescale 1ns/1ps

module tb_load_store_unit;
  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic [9:0]  mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_wr;
  logic [31:0] mem_wdata;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [31:0] ram     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        init_en;
  logic        poke_en;
  logic [9:0]  poke_idx;
  logic [31:0] poke_val;

  logic [31:0] last_data;
  logic        last_err;
  int          last_lat;
  int          last_wr_k;
  logic [9:0]  last_wr_a;
  logic [31:0] last_wr_d;

  load_store_unit #(.DEPTH_LOG2(10)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5C30F17;
  endfunction

  // RAM model: registered read, full-word write on the strobed edge
  always @(posedge clock) begin
    if (init_en) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
    end else if (poke_en) ram[poke_idx] <= poke_val;
    else if (mem_wr) ram[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clock);
    poke_en = 1'b1; poke_idx = 10'(idx); poke_val = val;
    @(posedge clock); #1;
    poke_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Issue one request and check it against the reference memory rules.
  task automatic do_req(input bit wr, input bit [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    int idx, off, g, lat, rd_n, wr_n, rd_k, wr_k;
    int exp_lat, exp_rd, exp_wr, exp_wr_k;
    bit is_byte, is_half, mis, trap;
    logic [31:0] old, lane, exp_data, new_word, wr_d, got_data;
    logic [9:0] rd_a, wr_a;
    logic got_err;

    idx = int'(addr >> 2) % 1024;
    is_byte = (sz == 2'd0);
    is_half = (sz == 2'd1);
    off = int'(addr & 32'd3);
    mis = (is_half && addr[0]) || (!is_byte && !is_half && off != 0);
`ifdef MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    if (is_half) off = off & 2;
    else if (!is_byte) off = 0;
    old = ref_mem[idx];
    exp_data = 32'd0; new_word = old; exp_wr_k = 0;
    if (trap) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (wr) begin
      exp_wr = 1;
      if (is_byte) begin
        new_word = (old & ~(32'hFF << (8 * off))) | ((wd & 32'hFF) << (8 * off));
        exp_lat = 4; exp_rd = 1; exp_wr_k = 3;
      end else if (is_half) begin
        new_word = (old & ~(32'hFFFF << (8 * off))) | ((wd & 32'hFFFF) << (8 * off));
        exp_lat = 4; exp_rd = 1; exp_wr_k = 3;
      end else begin
        new_word = wd;
        exp_lat = 2; exp_rd = 0; exp_wr_k = 1;
      end
    end else begin
      exp_lat = 3; exp_rd = 1; exp_wr = 0;
      if (is_byte) begin
        lane = (old >> (8 * off)) & 32'hFF;
        if (!uns && lane[7]) lane = lane | 32'hFFFFFF00;
      end else if (is_half) begin
        lane = (old >> (8 * off)) & 32'hFFFF;
        if (!uns && lane[15]) lane = lane | 32'hFFFF0000;
      end else lane = old;
      exp_data = lane;
    end

    @(negedge clock);
    g = 0;
    while (req_ready !== 1'b1 && g < 20) begin @(negedge clock); g++; end
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0;

    lat = 0; rd_n = 0; wr_n = 0; rd_k = 0; wr_k = 0;
    rd_a = '0; wr_a = '0; wr_d = '0; got_data = '0; got_err = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) chk("ready_busy", 32'(req_ready), 32'd0);
      if (mem_rd) begin rd_n++; rd_k = k; rd_a = mem_addr; end
      if (mem_wr) begin wr_n++; wr_k = k; wr_a = mem_addr; wr_d = mem_wdata; end
      if (resp_valid) begin lat = k; got_data = resp_data; got_err = resp_error; break; end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_data", got_data, exp_data);
    chk("resp_error", 32'(got_err), 32'(trap));
    chk("rd_count", 32'(rd_n), 32'(exp_rd));
    chk("wr_count", 32'(wr_n), 32'(exp_wr));
    if (exp_rd != 0) begin
      chk("rd_cycle", 32'(rd_k), 32'd1);
      chk("rd_addr", 32'(rd_a), 32'(idx));
    end
    if (exp_wr != 0) begin
      chk("wr_cycle", 32'(wr_k), 32'(exp_wr_k));
      chk("wr_addr", 32'(wr_a), 32'(idx));
      chk("wr_data", wr_d, new_word);
      ref_mem[idx] = new_word;
    end
    @(negedge clock);
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
    chk("ready_after_resp", 32'(req_ready), 32'd1);
    chk("ram_word", ram[idx], ref_mem[idx]);
    last_data = got_data; last_err = got_err; last_lat = lat;
    last_wr_k = wr_k; last_wr_a = wr_a; last_wr_d = wr_d;
  endtask

  initial begin
    int ok;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; poke_en = 1'b0; poke_idx = '0; poke_val = '0;
    reset_n = 1'b0; init_en = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

    // Reset state
    repeat (3) @(negedge clock);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_resp", {30'd0, resp_valid, resp_error}, 32'd0);
    chk("reset_resp_data", resp_data, 32'd0);
    chk("reset_mem_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    reset_n = 1'b1; init_en = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // Word store then word load
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("plan_wst_idx", 32'(last_wr_a), 32'd4);
    chk("plan_wst_cycle", 32'(last_wr_k), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("plan_wld_data", last_data, 32'hDEADBEEF);
    chk("plan_wld_lat", 32'(last_lat), 32'd3);

    // Byte RMW and byte loads
    poke(4, 32'h11223344);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA);
    chk("plan_bst_wdata", last_wr_d, 32'h1122AA44);
    do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    chk("plan_bld_signed", last_data, 32'hFFFFFFAA);
    do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    chk("plan_bld_unsigned", last_data, 32'h000000AA);

    // Half loads
    poke(4, 32'h8001FFFF);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    chk("plan_hld_signed", last_data, 32'hFFFF8001);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    chk("plan_hld_unsigned", last_data, 32'h00008001);
    do_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("plan_mis_err", 32'(last_err), 32'd1);
    chk("plan_mis_lat", 32'(last_lat), 32'd1);
`else
    chk("plan_mis_data", last_data, 32'hFFFF8001);
`endif

    // Address wrap and last word
    do_req(1'b0, 2'd2, 1'b0, 32'h00001000, 32'h0);
    do_req(1'b1, 2'd3, 1'b0, 32'h00000FFC, 32'hCAFEF00D);
    chk("plan_last_idx", 32'(last_wr_a), 32'd1023);

    // Reset during DATA of a sub-word store
    poke(7, 32'h55667788);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h1D; req_wdata = 32'h000000EE;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    ok = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (mem_wr !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) ok = 0;
    end
    chk("rst_mid_quiet", 32'(ok), 32'd1);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_ram", ram[7], 32'h55667788);

    // Random requests over a small hot region and the full address space
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clock);
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
